pal_cfg_loader: RTL and testbench

//  Upstream feeder for the PAL fabric's serial configuration chain.
//  - Accepts a configuration bitstream as bytes on a valid/ready interface.
//  - Serialises each byte MSB-first onto the PAL CFG input.
//  - Checks a trailing CRC-8 byte.
//  - Pulses the PAL EN (apply) input only when the CRC matches.
//  - Sits between the chip-level byte source and the PAL instance.

---
 rtl/pal_cfg_loader.sv | 142 ++++++++++++++
 tb/tb_pal_cfg_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_cfg_loader.sv
// Byte-stream loader for the PAL serial configuration chain: serialises bytes MSB-first,
// checks a trailing CRC-8 byte and pulses the apply strobe only on a CRC match.
module pal_cfg_loader #(
  parameter int unsigned CfgBits = 192,
  parameter logic [7:0]  CrcPoly = 8'h07
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       cfg_bit_o,
  output logic       cfg_shift_o,
  output logic       cfg_apply_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int unsigned NumBytes = CfgBits / 8;
  localparam int unsigned CntW     = $clog2(NumBytes + 1);
  localparam logic [CntW-1:0] NumBytesC = CntW'(NumBytes);

  typedef enum logic [2:0] {
    StIdle, StLoad, StShift, StCrc, StCheck, StApply, StDone, StError
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      shift_q, shift_d;
  logic            match_q, match_d;
  logic            idle_like;
  logic            hs;

  // Non-reflected CRC-8, whole byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CrcPoly) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign idle_like = (state_q == StIdle) || (state_q == StDone) || (state_q == StError);
  assign hs        = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: if (start_i) state_d = StLoad;
        StLoad:  if (in_valid_i) state_d = StShift;
        StShift: begin
          if (bit_cnt_q == 3'd7) state_d = (byte_cnt_q < NumBytesC) ? StLoad : StCrc;
        end
        StCrc:   if (in_valid_i) state_d = StCheck;
        StCheck: state_d = match_q ? StApply : StError;
        StApply: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = 1'b0;
    cfg_bit_o   = 1'b0;
    cfg_shift_o = 1'b0;
    cfg_apply_o = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    busy_o      = ~idle_like;
    unique case (state_q)
      StLoad, StCrc: in_ready_o = ~abort_i;
      StShift: begin
        cfg_shift_o = 1'b1;
        cfg_bit_o   = shift_q[7];
      end
      StApply: cfg_apply_o = ~abort_i;
      StDone:  done_o = 1'b1;
      StError: err_o = 1'b1;
      StIdle, StCheck: ;
      default: ;
    endcase
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    crc_d      = crc_q;
    shift_d    = shift_q;
    match_d    = match_q;
    if (abort_i || (idle_like && start_i)) begin
      byte_cnt_d = '0;
      bit_cnt_d  = '0;
      crc_d      = '0;
      shift_d    = '0;
      match_d    = 1'b0;
    end else if (state_q == StLoad && hs) begin
      shift_d    = in_data_i;
      crc_d      = crc8_byte(crc_q, in_data_i);
      byte_cnt_d = byte_cnt_q + 1'b1;
      bit_cnt_d  = '0;
    end else if (state_q == StShift) begin
      shift_d   = {shift_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end else if (state_q == StCrc && hs) begin
      match_d = (in_data_i == crc_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      crc_q      <= '0;
      shift_q    <= '0;
      match_q    <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      crc_q      <= crc_d;
      shift_q    <= shift_d;
      match_q    <= match_d;
    end
  end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Scoreboard bench for pal_cfg_loader: a 72-bit and a default 192-bit instance share the
// byte bus; a monitor pops expected serial bits and apply pulses as the DUTs emit them.
module tb_pal_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n    = 1'b0;
  logic       abort    = 1'b0;
  logic       start_a  = 1'b0;
  logic       start_b  = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;

  logic a_ready, a_bit, a_shift, a_apply, a_busy, a_done, a_err;
  logic b_ready, b_bit, b_shift, b_apply, b_busy, b_done, b_err;

  pal_cfg_loader #(.CfgBits(72)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(a_ready),
    .cfg_bit_o(a_bit), .cfg_shift_o(a_shift), .cfg_apply_o(a_apply),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
  );

  pal_cfg_loader u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(abort),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(b_ready),
    .cfg_bit_o(b_bit), .cfg_shift_o(b_shift), .cfg_apply_o(b_apply),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
  );

  int n_checks = 0;
  int n_fails  = 0;
  bit q_a[$];
  bit q_b[$];
  int apply_a  = 0;
  int apply_b  = 0;
  int shifts_a = 0;
  int shifts_b = 0;
  bit mon_en   = 1'b0;
  bit sel      = 1'b0;
  logic [7:0] stim[$];

  logic cur_ready, cur_busy;
  assign cur_ready = sel ? b_ready : a_ready;
  assign cur_busy  = sel ? b_busy : a_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_shift) begin
        shifts_a++;
        check("a_shift_has_expect", 32'(q_a.size() != 0), 1);
        if (q_a.size() != 0) check("a_cfg_bit", a_bit, q_a.pop_front());
      end else begin
        check("a_bit_zero_idle", a_bit, 0);
      end
      if (a_apply) begin
        check("a_apply_expected", 32'(apply_a != 0), 1);
        if (apply_a != 0) apply_a--;
      end
      if (b_shift) begin
        shifts_b++;
        check("b_shift_has_expect", 32'(q_b.size() != 0), 1);
        if (q_b.size() != 0) check("b_cfg_bit", b_bit, q_b.pop_front());
      end else begin
        check("b_bit_zero_idle", b_bit, 0);
      end
      if (b_apply) begin
        check("b_apply_expected", 32'(apply_b != 0), 1);
        if (apply_b != 0) apply_b--;
      end
    end
  end

  // Bit-serial CRC-8 reference over the first n bytes of stim.
  function automatic logic [7:0] crc_ref(input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ stim[k][i];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic pulse_start(input bit s);
    if (s) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic push_bits(input bit s, input logic [7:0] b);
    for (int k = 7; k >= 0; k--) begin
      if (s) q_b.push_back(b[k]);
      else q_a.push_back(b[k]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (cur_ready) break;
      n++;
      if (n > 100) begin
        check("handshake_timeout", cur_ready, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!cur_busy) break;
      n++;
      if (n > 100) begin
        check("idle_timeout", cur_busy, 0);
        break;
      end
    end
  endtask

  task automatic run_load(input bit s, input bit gaps, input int n, input logic [7:0] crc,
                          input bit ok, input int poke);
    int sh0;
    sel = s;
    sh0 = s ? shifts_b : shifts_a;
    pulse_start(s);
    for (int i = 0; i < n; i++) begin
      push_bits(s, stim[i]);
      send_byte(stim[i], gaps);
      if (i == poke) pulse_start(s);
    end
    if (ok) begin
      if (s) apply_b++;
      else apply_a++;
    end
    send_byte(crc, gaps);
    wait_idle();
    check("done", s ? b_done : a_done, 32'(ok));
    check("err", s ? b_err : a_err, 32'(!ok));
    check("busy", cur_busy, 0);
    check("shift_count", (s ? shifts_b : shifts_a) - sh0, 8 * n);
    check("bits_left", s ? q_b.size() : q_a.size(), 0);
    check("apply_pending", s ? apply_b : apply_a, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sh0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_a_ready", a_ready, 0); check("rst_a_shift", a_shift, 0);
    check("rst_a_apply", a_apply, 0); check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);   check("rst_a_err", a_err, 0);
    check("rst_b_ready", b_ready, 0); check("rst_b_shift", b_shift, 0);
    check("rst_b_busy", b_busy, 0);   check("rst_b_done", b_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Check string "123456789" with its known CRC-8 0xF4, then a corrupted CRC.
    stim = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_load(1'b0, 1'b0, 9, 8'hF4, 1'b1, -1);
    run_load(1'b0, 1'b0, 9, 8'hF5, 1'b0, -1);

    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back(8'h00);
    run_load(1'b1, 1'b1, 24, 8'h00, 1'b1, -1);

    // Abort after the fifth byte has fully shifted out.
    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back(8'(i * 7 + 3));
    sel = 1'b1;
    sh0 = shifts_b;
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) begin
      push_bits(1'b1, stim[i]);
      send_byte(stim[i], 1'b0);
    end
    for (int n = 0; n < 20 && !b_ready; n++) @(negedge clk);
    check("abort_pre_ready", b_ready, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", b_busy, 0);
    check("abort_ready", b_ready, 0);
    check("abort_done", b_done, 0);
    check("abort_a_err_cleared", a_err, 0);
    check("abort_shift_count", shifts_b - sh0, 40);
    @(posedge clk); #1;
    run_load(1'b1, 1'b0, 24, crc_ref(24), 1'b1, -1);

    // START during SHIFT must be ignored.
    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back(8'hA5 ^ 8'(i));
    run_load(1'b1, 1'b0, 24, crc_ref(24), 1'b1, 3);

    // Synchronous reset four bits into the second byte.
    sel = 1'b1;
    pulse_start(1'b1);
    for (int i = 0; i < 2; i++) begin
      push_bits(1'b1, stim[i]);
      send_byte(stim[i], 1'b0);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_shift", b_shift, 0); check("midrst_ready", b_ready, 0);
    check("midrst_busy", b_busy, 0);   check("midrst_done", b_done, 0);
    check("midrst_err", b_err, 0);     check("midrst_apply", b_apply, 0);
    check("midrst_bits_unsent", q_b.size(), 4);
    q_b.delete();
    repeat (5) @(negedge clk);
    check("midrst_stays_idle", b_busy, 0);
    @(posedge clk); #1;
    run_load(1'b1, 1'b0, 24, crc_ref(24), 1'b1, -1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
